// File: rtl/cci_mpf_svc_vtp_pkg.sv
// Shared types for the VTP translation service and its port arbiter.
package cci_mpf_svc_vtp_pkg;

  localparam int unsigned VTP_N_PORTS        = 2;
  localparam int unsigned VTP_VA_PAGE_WIDTH  = 36;
  localparam int unsigned VTP_PA_PAGE_WIDTH  = 28;
  localparam int unsigned VTP_TAG_WIDTH      = 4;
  localparam int unsigned VTP_PORT_IDX_WIDTH = $clog2(VTP_N_PORTS);

  typedef logic [VTP_VA_PAGE_WIDTH-1:0] t_tlb_va_page;
  typedef logic [VTP_PA_PAGE_WIDTH-1:0] t_tlb_pa_page;

  // Tag presented to the server: originating port in the upper bits.
  typedef struct packed {
    logic [VTP_PORT_IDX_WIDTH-1:0] port;
    logic [VTP_TAG_WIDTH-1:0]      tag;
  } t_vtp_svc_tag;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StIdle
  } t_vtp_arb_state;

endpackage

// File: rtl/cci_mpf_prim_arb_rr.sv
// Round-robin picker: one-hot grant to the first request after the previous winner.
module cci_mpf_prim_arb_rr #(
  parameter int unsigned NReq = 2,
  localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en_i,
  input  logic [NReq-1:0] req_i,
  output logic [NReq-1:0] gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] last_q;
  logic [IdxW-1:0] cand_idx;
  int unsigned     cand;

  // Walk from farthest to nearest so the nearest requester after last_q wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    cand      = 0;
    cand_idx  = '0;
    if (en_i) begin
      for (int unsigned k = NReq; k >= 1; k--) begin
        cand     = (32'(last_q) + k) % NReq;
        cand_idx = cand[IdxW-1:0];
        if (req_i[cand_idx]) begin
          gnt_o           = '0;
          gnt_o[cand_idx] = 1'b1;
          gnt_idx_o       = cand_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= IdxW'(NReq - 1);
    end else if (|gnt_o) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/cci_mpf_svc_vtp_port_arb.sv
// Shares one VTP translation server among N pipeline ports with per-port credits
// and a drain handshake used to quiesce translation before page table updates.
module cci_mpf_svc_vtp_port_arb
  import cci_mpf_svc_vtp_pkg::*;
#(
  parameter int unsigned N_PORTS         = VTP_N_PORTS,
  parameter int unsigned VA_PAGE_WIDTH   = VTP_VA_PAGE_WIDTH,
  parameter int unsigned PA_PAGE_WIDTH   = VTP_PA_PAGE_WIDTH,
  parameter int unsigned TAG_WIDTH       = VTP_TAG_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned PortW          = $clog2(N_PORTS),
  localparam int unsigned SvcTagW        = PortW + TAG_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_PORTS-1:0]           port_req_valid_i,
  output logic [N_PORTS-1:0]           port_req_ready_o,
  input  logic [N_PORTS*VA_PAGE_WIDTH-1:0] port_req_va_i,
  input  logic [N_PORTS*TAG_WIDTH-1:0] port_req_tag_i,
  output logic [N_PORTS-1:0]           port_rsp_valid_o,
  output logic [PA_PAGE_WIDTH-1:0]     port_rsp_pa_o,
  output logic [TAG_WIDTH-1:0]         port_rsp_tag_o,
  output logic                         port_rsp_err_o,
  output logic                         svc_req_valid_o,
  input  logic                         svc_req_ready_i,
  output logic [VA_PAGE_WIDTH-1:0]     svc_req_va_o,
  output logic [SvcTagW-1:0]           svc_req_tag_o,
  input  logic                         svc_rsp_valid_i,
  input  logic [SvcTagW-1:0]           svc_rsp_tag_i,
  input  logic [PA_PAGE_WIDTH-1:0]     svc_rsp_pa_i,
  input  logic                         svc_rsp_err_i,
  input  logic                         drain_req_i,
  output logic                         drain_done_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

  logic [1:0]               rst_sync_q;
  t_vtp_arb_state           state_q, state_d;
  logic                     run_en, drain_done_d, drain_done_q;
  logic                     slot_load, slot_valid_q, slot_valid_d;
  logic [VA_PAGE_WIDTH-1:0] slot_va_q;
  logic [SvcTagW-1:0]       slot_tag_q;
  logic [N_PORTS-1:0]       elig, gnt;
  logic [PortW-1:0]         gnt_idx;
  logic [VA_PAGE_WIDTH-1:0] gnt_va;
  logic [TAG_WIDTH-1:0]     gnt_tag;
  logic [PortW-1:0]         rsp_port;
  logic                     rsp_port_ok;
  logic [N_PORTS-1:0]       rsp_dec;
  logic [CntW-1:0]          cnt_q [N_PORTS];
  logic [CntW-1:0]          cnt_d [N_PORTS];
  logic                     cnt_zero_d;
  logic [N_PORTS-1:0]       rsp_valid_q;
  logic [PA_PAGE_WIDTH-1:0] rsp_pa_q;
  logic [TAG_WIDTH-1:0]     rsp_tag_q;
  logic                     rsp_err_q;

  // Grants stay off until reset release has passed through two flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      elig[i] = port_req_valid_i[i] && (cnt_q[i] < CntW'(MAX_OUTSTANDING)) && run_en;
    end
  end

  assign slot_load = !slot_valid_q || svc_req_ready_i;

  cci_mpf_prim_arb_rr #(
    .NReq (N_PORTS)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (slot_load),
    .req_i     (elig),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    gnt_va  = '0;
    gnt_tag = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt[i]) begin
        gnt_va  = port_req_va_i[i*VA_PAGE_WIDTH +: VA_PAGE_WIDTH];
        gnt_tag = port_req_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign slot_valid_d = slot_load ? |gnt : slot_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q <= 1'b0;
      slot_va_q    <= '0;
      slot_tag_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      if (slot_load && |gnt) begin
        slot_va_q  <= gnt_va;
        slot_tag_q <= {gnt_idx, gnt_tag};
      end
    end
  end

  assign rsp_port    = svc_rsp_tag_i[SvcTagW-1 -: PortW];
  assign rsp_port_ok = 32'(rsp_port) < N_PORTS;

  always_comb begin
    cnt_zero_d = 1'b1;
    for (int i = 0; i < N_PORTS; i++) begin
      rsp_dec[i] = svc_rsp_valid_i && rsp_port_ok && (rsp_port == PortW'(i));
      cnt_d[i]   = cnt_q[i];
      case ({gnt[i], rsp_dec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
        2'b01:   if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CntW'(1);
        default: ;
      endcase
      if (cnt_d[i] != '0) cnt_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_pa_q    <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_dec;
      if (|rsp_dec) begin
        rsp_pa_q  <= svc_rsp_pa_i;
        rsp_tag_q <= svc_rsp_tag_i[TAG_WIDTH-1:0];
        rsp_err_q <= svc_rsp_err_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StRun;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
    end
  end

  // Quiescence is judged on next-cycle values so done follows the last response by one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (drain_req_i) state_d = StDrain;
      StDrain: begin
        if (!drain_req_i)                     state_d = StRun;
        else if (!slot_valid_d && cnt_zero_d) state_d = StIdle;
      end
      StIdle:  if (!drain_req_i) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    run_en       = (state_q == StRun) && rst_sync_q[1];
    drain_done_d = (state_d == StIdle);
  end

  assign port_req_ready_o = gnt;
  assign svc_req_valid_o  = slot_valid_q;
  assign svc_req_va_o     = slot_va_q;
  assign svc_req_tag_o    = slot_tag_q;
  assign port_rsp_valid_o = rsp_valid_q;
  assign port_rsp_pa_o    = rsp_pa_q;
  assign port_rsp_tag_o   = rsp_tag_q;
  assign port_rsp_err_o   = rsp_err_q;
  assign drain_done_o     = drain_done_q;

`ifndef SYNTHESIS
  logic [N_PORTS-1:0] cnt_zero;
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) cnt_zero[i] = (cnt_q[i] == '0);
  end

  a_rsp_port_range: assert property (@(posedge clk) disable iff (!reset_n)
    svc_rsp_valid_i |-> rsp_port_ok);
  a_rsp_credit: assert property (@(posedge clk) disable iff (!reset_n)
    ~|(rsp_dec & cnt_zero));
`endif

endmodule

// File: tb/tb_cci_mpf_svc_vtp_port_arb.sv
// Directed and randomized checks of the VTP port arbiter against a queue-based model.
module tb_cci_mpf_svc_vtp_port_arb;

  localparam int NP = 2, VAW = 36, PAW = 28, TW = 4, MAXO = 8, STW = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NP-1:0]     port_req_valid = '0;
  logic [NP-1:0]     port_req_ready;
  logic [NP*VAW-1:0] port_req_va = '0;
  logic [NP*TW-1:0]  port_req_tag = '0;
  logic [NP-1:0]     port_rsp_valid;
  logic [PAW-1:0]    port_rsp_pa;
  logic [TW-1:0]     port_rsp_tag;
  logic              port_rsp_err;
  logic              svc_req_valid;
  logic              svc_req_ready = 1'b0;
  logic [VAW-1:0]    svc_req_va;
  logic [STW-1:0]    svc_req_tag;
  logic              svc_rsp_valid = 1'b0;
  logic [STW-1:0]    svc_rsp_tag = '0;
  logic [PAW-1:0]    svc_rsp_pa = '0;
  logic              svc_rsp_err = 1'b0;
  logic              drain_req = 1'b0;
  logic              drain_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cci_mpf_svc_vtp_port_arb dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .port_req_valid_i (port_req_valid),
    .port_req_ready_o (port_req_ready),
    .port_req_va_i    (port_req_va),
    .port_req_tag_i   (port_req_tag),
    .port_rsp_valid_o (port_rsp_valid),
    .port_rsp_pa_o    (port_rsp_pa),
    .port_rsp_tag_o   (port_rsp_tag),
    .port_rsp_err_o   (port_rsp_err),
    .svc_req_valid_o  (svc_req_valid),
    .svc_req_ready_i  (svc_req_ready),
    .svc_req_va_o     (svc_req_va),
    .svc_req_tag_o    (svc_req_tag),
    .svc_rsp_valid_i  (svc_rsp_valid),
    .svc_rsp_tag_i    (svc_rsp_tag),
    .svc_rsp_pa_i     (svc_rsp_pa),
    .svc_rsp_err_i    (svc_rsp_err),
    .drain_req_i      (drain_req),
    .drain_done_o     (drain_done)
  );

  // Server behaviour used by the random test.
  function automatic logic [PAW-1:0] xlate(input logic [VAW-1:0] va);
    return va[PAW-1:0] ^ 28'h5A5A5A5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    port_req_valid = '0;
    port_req_va    = '0;
    port_req_tag   = '0;
    svc_req_ready  = 1'b0;
    svc_rsp_valid  = 1'b0;
    svc_rsp_tag    = '0;
    svc_rsp_pa     = '0;
    svc_rsp_err    = 1'b0;
    drain_req      = 1'b0;
  endtask

  // Returns two edges after release, when grants become possible.
  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    port_req_valid = 2'b11;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (svc_req_valid !== 1'b0 || port_req_ready !== 2'b00 || port_rsp_valid !== 2'b00 ||
        drain_done !== 1'b0)
      $display("FAIL reset_ctrl: got sv=%b rdy=%b rv=%b dd=%b want 0 00 00 0",
               svc_req_valid, port_req_ready, port_rsp_valid, drain_done);
    else n_pass++;
    n_checks++;
    if (svc_req_va !== '0 || svc_req_tag !== '0 || port_rsp_pa !== '0 || port_rsp_tag !== '0)
      $display("FAIL reset_data: got va=%h tag=%h pa=%h rtag=%h want all 0",
               svc_req_va, svc_req_tag, port_rsp_pa, port_rsp_tag);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    #1;
    n_checks++;
    if (port_req_ready !== 2'b00)
      $display("FAIL reset_sync_hold: got %b want 00", port_req_ready);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (port_req_ready !== 2'b01)
      $display("FAIL reset_first_grant: got %b want 01", port_req_ready);
    else n_pass++;
    port_req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    port_req_valid        = 2'b01;
    port_req_va[0 +: VAW] = 36'h123;
    port_req_tag[0 +: TW] = 4'h5;
    svc_req_ready         = 1'b1;
    #1;
    n_checks++;
    if (port_req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", port_req_ready);
    else n_pass++;
    tick();
    port_req_valid = '0;
    svc_rsp_valid  = 1'b1;
    svc_rsp_tag    = 5'h05;
    svc_rsp_pa     = 28'h45;
    svc_rsp_err    = 1'b0;
    #1;
    n_checks++;
    if (svc_req_valid !== 1'b1 || svc_req_va !== 36'h123 || svc_req_tag !== 5'h05)
      $display("FAIL single_svc_req: got v=%b va=%h tag=%h want 1 123 05",
               svc_req_valid, svc_req_va, svc_req_tag);
    else n_pass++;
    tick();
    svc_rsp_valid = 1'b0;
    #1;
    n_checks++;
    if (port_rsp_valid !== 2'b01 || port_rsp_pa !== 28'h45 || port_rsp_tag !== 4'h5 ||
        port_rsp_err !== 1'b0)
      $display("FAIL single_rsp: got v=%b pa=%h tag=%h err=%b want 01 45 5 0",
               port_rsp_valid, port_rsp_pa, port_rsp_tag, port_rsp_err);
    else n_pass++;
    n_checks++;
    if (svc_req_valid !== 1'b0) $display("FAIL single_slot_empty: got %b want 0", svc_req_valid);
    else n_pass++;
  endtask

  task automatic test_fairness();
    logic [1:0] exp;
    do_reset();
    port_req_valid          = 2'b11;
    port_req_va[0 +: VAW]   = 36'hA0;
    port_req_va[VAW +: VAW] = 36'hB1;
    svc_req_ready           = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_checks++;
      if (port_req_ready !== exp)
        $display("FAIL fair_grant_%0d: got %b want %b", k, port_req_ready, exp);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (svc_req_tag[STW-1] !== ((k - 1) % 2 == 1))
          $display("FAIL fair_tag_port_%0d: got %b want %0d", k, svc_req_tag[STW-1], (k - 1) % 2);
        else n_pass++;
      end
      tick();
    end
    port_req_valid = '0;
  endtask

  task automatic test_credit();
    do_reset();
    svc_req_ready  = 1'b1;
    port_req_valid = 2'b10;
    for (int k = 0; k < MAXO; k++) begin
      #1;
      n_checks++;
      if (port_req_ready !== 2'b10)
        $display("FAIL credit_fill_%0d: got %b want 10", k, port_req_ready);
      else n_pass++;
      tick();
    end
    port_req_valid = 2'b11;
    #1;
    n_checks++;
    if (port_req_ready !== 2'b01) $display("FAIL credit_stall: got %b want 01", port_req_ready);
    else n_pass++;
    tick();
    port_req_valid = 2'b10;
    svc_rsp_valid  = 1'b1;
    svc_rsp_tag    = 5'h10;
    #1;
    n_checks++;
    if (port_req_ready !== 2'b00) $display("FAIL credit_full: got %b want 00", port_req_ready);
    else n_pass++;
    tick();
    svc_rsp_valid = 1'b0;
    #1;
    n_checks++;
    if (port_req_ready !== 2'b10) $display("FAIL credit_reenable: got %b want 10", port_req_ready);
    else n_pass++;
    tick();
    port_req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    port_req_valid        = 2'b01;
    port_req_va[0 +: VAW] = 36'hABCDE;
    port_req_tag[0 +: TW] = 4'h3;
    svc_req_ready         = 1'b0;
    #1;
    n_checks++;
    if (port_req_ready !== 2'b01) $display("FAIL bp_load_empty: got %b want 01", port_req_ready);
    else n_pass++;
    tick();
    port_req_va[0 +: VAW] = 36'h11111;
    port_req_tag[0 +: TW] = 4'h9;
    port_req_valid        = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (svc_req_valid !== 1'b1 || svc_req_va !== 36'hABCDE || svc_req_tag !== 5'h03 ||
          port_req_ready !== 2'b00)
        $display("FAIL bp_hold_%0d: got v=%b va=%h tag=%h rdy=%b want 1 abcde 03 00",
                 k, svc_req_valid, svc_req_va, svc_req_tag, port_req_ready);
      else n_pass++;
      tick();
    end
    svc_req_ready = 1'b1;
    #1;
    n_checks++;
    if (port_req_ready !== 2'b10) $display("FAIL bp_release: got %b want 10", port_req_ready);
    else n_pass++;
    tick();
    port_req_valid = '0;
  endtask

  task automatic test_drain();
    logic [STW-1:0] rtags [3];
    rtags[0] = 5'h01;
    rtags[1] = 5'h12;
    rtags[2] = 5'h03;
    do_reset();
    svc_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      port_req_valid = (k == 1) ? 2'b10 : 2'b01;
      port_req_tag   = {rtags[1][TW-1:0], (k == 0) ? rtags[0][TW-1:0] : rtags[2][TW-1:0]};
      tick();
    end
    port_req_valid = '0;
    drain_req      = 1'b1;
    tick();
    port_req_valid = 2'b11;
    #1;
    n_checks++;
    if (port_req_ready !== 2'b00 || drain_done !== 1'b0)
      $display("FAIL drain_block: got rdy=%b dd=%b want 00 0", port_req_ready, drain_done);
    else n_pass++;
    tick();
    for (int k = 0; k < 3; k++) begin
      svc_rsp_valid = 1'b1;
      svc_rsp_tag   = rtags[k];
      #1;
      n_checks++;
      if (port_req_ready !== 2'b00 || drain_done !== 1'b0)
        $display("FAIL drain_wait_%0d: got rdy=%b dd=%b want 00 0", k, port_req_ready, drain_done);
      else n_pass++;
      tick();
    end
    svc_rsp_valid = 1'b0;
    #1;
    n_checks++;
    if (drain_done !== 1'b1 || port_req_ready !== 2'b00)
      $display("FAIL drain_done: got dd=%b rdy=%b want 1 00", drain_done, port_req_ready);
    else n_pass++;
    tick();
    drain_req = 1'b0;
    #1;
    n_checks++;
    if (drain_done !== 1'b1 || port_req_ready !== 2'b00)
      $display("FAIL drain_idle_hold: got dd=%b rdy=%b want 1 00", drain_done, port_req_ready);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (port_req_ready !== 2'b10 || drain_done !== 1'b0)
      $display("FAIL drain_resume: got rdy=%b dd=%b want 10 0", port_req_ready, drain_done);
    else n_pass++;
    tick();
    port_req_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    port_req_valid = 2'b11;
    svc_req_ready  = 1'b1;
    repeat (3) tick();
    svc_rsp_valid = 1'b1;
    svc_rsp_tag   = 5'h00;
    tick();
    svc_rsp_valid = 1'b0;
    #1;
    n_checks++;
    if (port_rsp_valid !== 2'b01 || svc_req_valid !== 1'b1)
      $display("FAIL areset_pre: got rv=%b sv=%b want 01 1", port_rsp_valid, svc_req_valid);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (svc_req_valid !== 1'b0 || port_rsp_valid !== 2'b00 || port_req_ready !== 2'b00)
      $display("FAIL areset_immediate: got sv=%b rv=%b rdy=%b want 0 00 00",
               svc_req_valid, port_rsp_valid, port_req_ready);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (port_req_ready !== 2'b00) $display("FAIL areset_rel0: got %b want 00", port_req_ready);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (port_req_ready !== 2'b00) $display("FAIL areset_rel1: got %b want 00", port_req_ready);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (port_req_ready !== 2'b01) $display("FAIL areset_rel2: got %b want 01", port_req_ready);
    else n_pass++;
    port_req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int             m_cnt [NP];
    int             m_last;
    bit             m_slot_v;
    logic [VAW-1:0] m_slot_va;
    logic [STW-1:0] m_slot_tag;
    logic [STW-1:0] q_tag [$];
    logic [VAW-1:0] q_va [$];
    bit             e_rsp_v;
    int             e_rsp_port;
    logic [PAW-1:0] e_pa;
    logic [TW-1:0]  e_tag;
    logic           e_err;
    int             g, p, idx, rport;
    logic [NP-1:0]  e_rdy, e_rv;
    do_reset();
    for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    m_last   = NP - 1;
    m_slot_v = 0;
    e_rsp_v  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      port_req_valid = NP'($urandom_range(0, 3));
      for (int i = 0; i < NP; i++) begin
        port_req_va[i*VAW +: VAW] = {4'($urandom), 32'($urandom)};
        port_req_tag[i*TW +: TW]  = TW'($urandom);
      end
      svc_req_ready = ($urandom_range(0, 3) != 0);
      rport = -1;
      if (q_tag.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx           = $urandom_range(0, q_tag.size() - 1);
        svc_rsp_valid = 1'b1;
        svc_rsp_tag   = q_tag[idx];
        svc_rsp_pa    = xlate(q_va[idx]);
        svc_rsp_err   = ^q_va[idx][3:0];
        rport         = int'(q_tag[idx][STW-1]);
        q_tag.delete(idx);
        q_va.delete(idx);
      end else begin
        svc_rsp_valid = 1'b0;
      end
      #1;
      // Round-robin choice among ports with credit, starting after the last winner.
      g = -1;
      if (!m_slot_v || svc_req_ready) begin
        for (int k = NP; k >= 1; k--) begin
          p = (m_last + k) % NP;
          if (port_req_valid[p] && m_cnt[p] < MAXO) g = p;
        end
      end
      e_rdy = (g < 0) ? '0 : NP'(1 << g);
      n_checks++;
      if (port_req_ready !== e_rdy)
        $display("FAIL rnd_ready_%0d: got %b want %b", cyc, port_req_ready, e_rdy);
      else n_pass++;
      n_checks++;
      if (svc_req_valid !== m_slot_v)
        $display("FAIL rnd_svc_valid_%0d: got %b want %b", cyc, svc_req_valid, m_slot_v);
      else n_pass++;
      if (m_slot_v) begin
        n_checks++;
        if (svc_req_va !== m_slot_va || svc_req_tag !== m_slot_tag)
          $display("FAIL rnd_svc_data_%0d: got va=%h tag=%h want va=%h tag=%h",
                   cyc, svc_req_va, svc_req_tag, m_slot_va, m_slot_tag);
        else n_pass++;
      end
      e_rv = e_rsp_v ? NP'(1 << e_rsp_port) : '0;
      n_checks++;
      if (port_rsp_valid !== e_rv)
        $display("FAIL rnd_rsp_valid_%0d: got %b want %b", cyc, port_rsp_valid, e_rv);
      else n_pass++;
      if (e_rsp_v) begin
        n_checks++;
        if (port_rsp_pa !== e_pa || port_rsp_tag !== e_tag || port_rsp_err !== e_err)
          $display("FAIL rnd_rsp_data_%0d: got pa=%h tag=%h err=%b want pa=%h tag=%h err=%b",
                   cyc, port_rsp_pa, port_rsp_tag, port_rsp_err, e_pa, e_tag, e_err);
        else n_pass++;
      end
      if (m_slot_v && svc_req_ready) begin
        q_tag.push_back(m_slot_tag);
        q_va.push_back(m_slot_va);
        m_slot_v = 0;
      end
      if (g >= 0) begin
        m_slot_v   = 1;
        m_slot_va  = port_req_va[g*VAW +: VAW];
        m_slot_tag = {1'(g), port_req_tag[g*TW +: TW]};
        m_last     = g;
        m_cnt[g]++;
      end
      e_rsp_v = (rport >= 0);
      if (rport >= 0) begin
        m_cnt[rport]--;
        e_rsp_port = rport;
        e_pa       = svc_rsp_pa;
        e_tag      = svc_rsp_tag[TW-1:0];
        e_err      = svc_rsp_err;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_credit();
    test_backpressure();
    test_drain();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
